// File: rtl/kamus_csr_counters_if.sv
// rtl/kamus_csr_counters_if.sv - CSR access bus between the kamus execute stage and the counter unit
interface kamus_csr_counters_if;
    logic        csr_req_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic        csr_ack_o;
    logic [31:0] csr_rdata_o;
    logic        csr_err_o;

    modport master (
        output csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
        input  csr_ack_o, csr_rdata_o, csr_err_o
    );

    modport slave (
        input  csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
        output csr_ack_o, csr_rdata_o, csr_err_o
    );
endinterface

// File: rtl/kamus_csr_counters.sv
// rtl/kamus_csr_counters.sv - mcycle/minstret/mhpmcounter CSRs and, with KAMUS_MTIME_EN, mtime/mtimecmp and timer interrupt
module kamus_csr_counters #(
    parameter int CNT_WIDTH = 64,
    parameter int NUM_HPM   = 2,
    parameter int TIME_DIV  = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    kamus_csr_counters_if.slave                   csr,
    input  logic                                  instr_retire_i,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event_i,
    output logic                                  timer_irq_o
);
    localparam int NCNT = 2 + NUM_HPM;
    localparam logic [6:0] HPM_END = 7'(3 + NUM_HPM);
    localparam logic [CNT_WIDTH-1:0] LO_MASK = CNT_WIDTH'(64'hFFFF_FFFF);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    // index 0 = mcycle, 1 = minstret, 2.. = mhpmcounter0..
    logic [CNT_WIDTH-1:0] cnt_q [NCNT];
    logic [NCNT-1:0]      inc;

`ifdef KAMUS_MTIME_EN
    localparam logic [7:0] PRESC_MAX = 8'(TIME_DIV - 1);
    logic [CNT_WIDTH-1:0] mtime_q;
    logic [CNT_WIDTH-1:0] mtimecmp_q;
    logic [7:0]           presc_q;
    logic                 irq_q;
`endif

    logic [6:0]           lo7;
    logic                 hit_cnt;
    logic [3:0]           hit_idx;
    logic                 hit_hi;
    logic                 hit_ro;
    logic                 hit_time;
    logic                 hit_cmp;
    logic                 acc_err;
    logic                 wr;
    logic [CNT_WIDTH-1:0] sel_val;
    logic [31:0]          old32;
    logic [31:0]          new32;
    logic [CNT_WIDTH-1:0] merged;

    assign lo7 = csr.csr_addr_i[6:0];

    generate
        if (NUM_HPM > 0) begin : g_inc_hpm
            assign inc = {hpm_event_i, instr_retire_i, 1'b1};
        end else begin : g_inc_base
            assign inc = {instr_retire_i, 1'b1};
        end
    endgenerate

    always_comb begin
        hit_cnt  = 1'b0;
        hit_idx  = 4'd0;
        hit_hi   = csr.csr_addr_i[7];
        hit_ro   = 1'b0;
        hit_time = 1'b0;
        hit_cmp  = 1'b0;
        if (csr.csr_addr_i[11:8] == 4'hF || csr.csr_addr_i[11:8] == 4'hC) begin
            hit_ro = (csr.csr_addr_i[11:8] == 4'hC);
            if (lo7 == 7'd0) begin
                hit_cnt = 1'b1;
                hit_idx = 4'd0;
            end else if (lo7 == 7'd2) begin
                hit_cnt = 1'b1;
                hit_idx = 4'd1;
            end else if (!hit_ro && lo7 >= 7'd3 && lo7 < HPM_END) begin
                hit_cnt = 1'b1;
                hit_idx = 4'(lo7 - 7'd1);
            end
`ifdef KAMUS_MTIME_EN
            else if (lo7 == 7'd1) begin
                hit_time = 1'b1;
            end
`endif
        end
`ifdef KAMUS_MTIME_EN
        // mtimecmp halves sit at 7C1/7C2, so bit 7 is not the half select there
        if (csr.csr_addr_i == 12'h7C1) begin
            hit_cmp = 1'b1;
            hit_hi  = 1'b0;
        end else if (csr.csr_addr_i == 12'h7C2) begin
            hit_cmp = 1'b1;
            hit_hi  = 1'b1;
        end
`endif
    end

    assign acc_err = !(hit_cnt || hit_time || hit_cmp) || (hit_ro && csr.csr_op_i != OP_READ);
    assign wr      = csr.csr_req_i && !acc_err && csr.csr_op_i != OP_READ;

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (hit_cnt && hit_idx == 4'(i)) begin
                sel_val = cnt_q[i];
            end
        end
`ifdef KAMUS_MTIME_EN
        if (hit_time) begin
            sel_val = mtime_q;
        end
        if (hit_cmp) begin
            sel_val = mtimecmp_q;
        end
`endif
    end

    assign old32 = hit_hi ? 32'(sel_val >> 32) : sel_val[31:0];

    always_comb begin
        case (csr.csr_op_i)
            OP_WRITE: new32 = csr.csr_wdata_i;
            OP_SET:   new32 = old32 | csr.csr_wdata_i;
            OP_READ:  new32 = old32;
            default:  new32 = old32 & ~csr.csr_wdata_i;
        endcase
    end

    // Splice the new half into the full-width value; high bits past CNT_WIDTH fall off
    assign merged = hit_hi ? ((sel_val & LO_MASK) | CNT_WIDTH'({32'd0, new32} << 32))
                           : ((sel_val & ~LO_MASK) | CNT_WIDTH'(new32));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                if (wr && hit_cnt && hit_idx == 4'(i)) begin
                    cnt_q[i] <= merged;
                end else if (inc[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

`ifdef KAMUS_MTIME_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q    <= '0;
            presc_q    <= 8'd0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            if (wr && hit_time) begin
                mtime_q <= merged;
                presc_q <= 8'd0;
            end else if (presc_q == PRESC_MAX) begin
                mtime_q <= mtime_q + CNT_WIDTH'(1);
                presc_q <= 8'd0;
            end else begin
                presc_q <= presc_q + 8'd1;
            end
            if (wr && hit_cmp) begin
                mtimecmp_q <= merged;
            end
            irq_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign timer_irq_o = irq_q;
`else
    assign timer_irq_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csr.csr_ack_o   <= 1'b0;
            csr.csr_rdata_o <= 32'd0;
            csr.csr_err_o   <= 1'b0;
        end else begin
            csr.csr_ack_o   <= csr.csr_req_i;
            csr.csr_rdata_o <= (csr.csr_req_i && !acc_err) ? old32 : 32'd0;
            csr.csr_err_o   <= csr.csr_req_i && acc_err;
        end
    end
endmodule

// File: tb/tb_kamus_csr_counters.sv
// tb/tb_kamus_csr_counters.sv - directed and randomized bench for kamus_csr_counters against a behavioural model
module tb_kamus_csr_counters;
    localparam int NH = 2;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       retire;
    logic [1:0] ev;
    logic       irq;

    always #5 clk = ~clk;

    kamus_csr_counters_if bus();

    kamus_csr_counters #(.CNT_WIDTH(64), .NUM_HPM(NH), .TIME_DIV(TD)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .csr           (bus.slave),
        .instr_retire_i(retire),
        .hpm_event_i   (ev),
        .timer_irq_o   (irq)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] m_cnt [2 + NH];
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    int          m_presc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2 + NH; i++) m_cnt[i] = 64'd0;
        m_mtime = 64'd0;
        m_cmp   = '1;
        m_presc = 0;
    endtask

    // kind: 0..1+NH counters, 100 mtime, 101 mtimecmp, -1 unmapped
    function automatic void lookup(input logic [11:0] a, output int kind, output bit hi, output bit ro);
        kind = -1;
        hi   = a[7];
        ro   = (a[11:8] == 4'hC);
        case (a)
            12'hF00, 12'hF80, 12'hC00, 12'hC80: kind = 0;
            12'hF02, 12'hF82, 12'hC02, 12'hC82: kind = 1;
`ifdef KAMUS_MTIME_EN
            12'hF01, 12'hF81, 12'hC01, 12'hC81: kind = 100;
            12'h7C1: begin kind = 101; hi = 1'b0; end
            12'h7C2: begin kind = 101; hi = 1'b1; end
`endif
            default: begin
                for (int n = 0; n < NH; n++) begin
                    if (a == 12'hF03 + 12'(n) || a == 12'hF83 + 12'(n)) kind = 2 + n;
                end
            end
        endcase
    endfunction

    task automatic cyc(input bit rq, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input bit ret, input logic [1:0] e);
        int          k;
        bit          hi, ro, err, wr, exp_irq;
        logic [63:0] old, nv;
        logic [31:0] o32, n32;
        bus.csr_req_i   = rq;
        bus.csr_op_i    = op;
        bus.csr_addr_i  = a;
        bus.csr_wdata_i = wd;
        retire          = ret;
        ev              = e;
        lookup(a, k, hi, ro);
        err = (k < 0) || (ro && op != 2'b00);
        if (k >= 0 && k < 2 + NH) old = m_cnt[k];
        else if (k == 100)        old = m_mtime;
        else if (k == 101)        old = m_cmp;
        else                      old = 64'd0;
        o32 = hi ? old[63:32] : old[31:0];
        case (op)
            2'b01:   n32 = wd;
            2'b10:   n32 = o32 | wd;
            2'b11:   n32 = o32 & ~wd;
            default: n32 = o32;
        endcase
        nv = hi ? {n32, old[31:0]} : {old[63:32], n32};
        wr = rq && !err && op != 2'b00;
`ifdef KAMUS_MTIME_EN
        exp_irq = (m_mtime >= m_cmp);
`else
        exp_irq = 1'b0;
`endif
        for (int i = 0; i < 2 + NH; i++) begin
            bit bump;
            bump = (i == 0) ? 1'b1 : (i == 1) ? ret : e[i-2];
            if (wr && k == i) m_cnt[i] = nv;
            else if (bump)    m_cnt[i] = m_cnt[i] + 64'd1;
        end
`ifdef KAMUS_MTIME_EN
        if (wr && k == 100) begin
            m_mtime = nv;
            m_presc = 0;
        end else if (m_presc == TD - 1) begin
            m_mtime = m_mtime + 64'd1;
            m_presc = 0;
        end else begin
            m_presc++;
        end
        if (wr && k == 101) m_cmp = nv;
`endif
        @(posedge clk);
        #1;
        check("ack", 64'(bus.csr_ack_o), 64'(rq));
        if (rq) begin
            check($sformatf("err@%h", a), 64'(bus.csr_err_o), 64'(err));
            check($sformatf("rdata@%h", a), 64'(bus.csr_rdata_o), err ? 64'd0 : 64'(o32));
        end
        check("irq", 64'(irq), 64'(exp_irq));
    endtask

    task automatic idle();
        cyc(1'b0, 2'b00, 12'h000, 32'd0, 1'b0, 2'b00);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.csr_req_i   = 1'b0;
        bus.csr_op_i    = 2'b00;
        bus.csr_addr_i  = 12'h000;
        bus.csr_wdata_i = 32'd0;
        retire          = 1'b0;
        ev              = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 64'(bus.csr_ack_o), 64'd0);
        check("rst_err", 64'(bus.csr_err_o), 64'd0);
        check("rst_rdata", 64'(bus.csr_rdata_o), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        rst = 1'b0;
        model_reset();
    endtask

    logic [11:0] addr_tab [22] = '{12'hF00, 12'hF80, 12'hF02, 12'hF82, 12'hF03, 12'hF83,
                                   12'hF04, 12'hF84, 12'hF05, 12'hF85, 12'hC00, 12'hC80,
                                   12'hC02, 12'hC82, 12'hF01, 12'hF81, 12'hC01, 12'hC81,
                                   12'h7C1, 12'h7C2, 12'h123, 12'hB00};

    initial begin
        bit seen;
        do_reset();

        // mcycle alias read at cycle 10 after reset release
        repeat (10) idle();
        cyc(1'b1, 2'b00, 12'hC00, 32'd0, 1'b0, 2'b00);
        check("c00_at_10", 64'(bus.csr_rdata_o), 64'd10);
        cyc(1'b1, 2'b00, 12'hC80, 32'd0, 1'b0, 2'b00);
        check("c80_zero", 64'(bus.csr_rdata_o), 64'd0);

        // mcycle wrap through all-ones
        cyc(1'b1, 2'b01, 12'hF00, 32'hFFFF_FFFF, 1'b0, 2'b00);
        cyc(1'b1, 2'b01, 12'hF80, 32'hFFFF_FFFF, 1'b0, 2'b00);
        idle();
        idle();
        cyc(1'b1, 2'b00, 12'hF00, 32'd0, 1'b0, 2'b00);
        check("mcycle_wrap", 64'(bus.csr_rdata_o), 64'd1);

        // set on minstret overrides the same-cycle retire
        cyc(1'b1, 2'b01, 12'hF02, 32'd3, 1'b0, 2'b00);
        cyc(1'b1, 2'b01, 12'hF82, 32'd0, 1'b0, 2'b00);
        cyc(1'b1, 2'b10, 12'hF02, 32'h10, 1'b1, 2'b00);
        check("minstret_set_old", 64'(bus.csr_rdata_o), 64'd3);
        cyc(1'b1, 2'b00, 12'hF02, 32'd0, 1'b0, 2'b00);
        check("minstret_set_new", 64'(bus.csr_rdata_o), 64'h13);

        // illegal accesses
        cyc(1'b1, 2'b01, 12'hC02, 32'hDEAD, 1'b0, 2'b00);
        check("c02_write_err", 64'(bus.csr_err_o), 64'd1);
        cyc(1'b1, 2'b00, 12'hF02, 32'd0, 1'b0, 2'b00);
        check("minstret_kept", 64'(bus.csr_rdata_o), 64'h13);
        cyc(1'b1, 2'b00, 12'hF03 + 12'(NH), 32'd0, 1'b0, 2'b00);
        check("hpm_oob_err", 64'(bus.csr_err_o), 64'd1);
        check("hpm_oob_rdata", 64'(bus.csr_rdata_o), 64'd0);

`ifdef KAMUS_MTIME_EN
        do_reset();
        cyc(1'b1, 2'b01, 12'h7C2, 32'd0, 1'b0, 2'b00);
        cyc(1'b1, 2'b01, 12'h7C1, 32'd5, 1'b0, 2'b00);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            idle();
            seen = irq;
        end
        check("irq_rises", 64'(seen), 64'd1);
        cyc(1'b1, 2'b01, 12'h7C1, 32'hFFFF_FFFF, 1'b0, 2'b00);
        idle();
        check("irq_clears", 64'(irq), 64'd0);
`else
        cyc(1'b1, 2'b00, 12'hF01, 32'd0, 1'b0, 2'b00);
        check("f01_err", 64'(bus.csr_err_o), 64'd1);
        cyc(1'b1, 2'b00, 12'h7C1, 32'd0, 1'b0, 2'b00);
        check("7c1_err", 64'(bus.csr_err_o), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            idle();
            seen = seen | irq;
        end
        check("irq_never", 64'(seen), 64'd0);
`endif

        // reset asserted alongside a request drops its ack
        rst            = 1'b1;
        bus.csr_req_i  = 1'b1;
        bus.csr_op_i   = 2'b00;
        bus.csr_addr_i = 12'hF00;
        @(posedge clk);
        #1;
        check("rst_drops_ack", 64'(bus.csr_ack_o), 64'd0);
        do_reset();
        idle();
        check("no_ack_after_rst", 64'(bus.csr_ack_o), 64'd0);

        for (int i = 0; i < 800; i++) begin
            logic [31:0] wd;
            wd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            cyc($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                addr_tab[$urandom_range(0, 21)], wd,
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
